// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: widths, opcodes,
// flag bit positions and FSM state encoding.
package seq_alu_pkg;

    localparam int DW  = 16;
    localparam int SAW = 4;
    localparam int CW  = SAW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the issue logic
// and the multi-cycle ALU.
interface seq_alu_if;
    import seq_alu_pkg::*;

    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          setFlags;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [3:0]    condFlag;
    logic          flagWe;

    modport master (
        output start, op, opA, opB, setFlags,
        input  busy, done, result, condFlag, flagWe
    );

    modport slave (
        input  start, op, opA, opB, setFlags,
        output busy, done, result, condFlag, flagWe
    );

endinterface

// File: rtl/seq_alu_flag_gen.sv
// Builds the {N,Z,C,V} flag nibble from a finished
// result plus the carry/overflow of its producing path.
module alu_flag_gen
    import seq_alu_pkg::*;
(
    input  logic [DW-1:0] res,
    input  logic          carry,
    input  logic          ovf,
    output logic [3:0]    flags
);

    // Pack the four condition bits at their fixed positions
    always_comb begin
        flags        = 4'b0000;
        flags[FLG_N] = res[DW-1];
        flags[FLG_Z] = (res == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute ALU: single-cycle logic/arith,
// 1-bit/cycle shifts and a shift-add multiplier.
module seq_alu
    import seq_alu_pkg::*;
(
    input  logic     clk,
    input  logic     nreset,
    seq_alu_if.slave bus
);

    state_e          state, stateNxt;
    logic [CW-1:0]   cnt, cntNxt;
    logic [3:0]      opReg, opNxt;
    logic            sfReg, sfNxt;
    logic [DW-1:0]   wrk, wrkNxt;
    logic [2*DW-1:0] mcand, mcandNxt;
    logic [DW-1:0]   mplr, mplrNxt;
    logic [2*DW-1:0] acc, accNxt;

    logic            doneR, flagWeR;
    logic [DW-1:0]   resultR;
    logic [3:0]      condR;

    logic            fin, finLegal, finC, finV;
    logic [DW-1:0]   finRes;
    logic [3:0]      finFlags;

    logic [DW:0]     addSum, subSum;
    logic [DW-1:0]   shVal;
    logic            shOut;
    logic [2*DW-1:0] mulStep;
    logic [SAW-1:0]  amt;

    assign addSum  = {1'b0, bus.opA} + {1'b0, bus.opB};
    assign subSum  = {1'b0, bus.opA} + {1'b0, ~bus.opB} + 17'd1;
    assign mulStep = acc + (mplr[0] ? mcand : '0);
    assign amt     = bus.opB[SAW-1:0];

    // One-bit step of the latched shift op
    always_comb begin
        shVal = wrk;
        shOut = 1'b0;
        case (opReg)
            OP_SHL: begin
                shVal = {wrk[DW-2:0], 1'b0};
                shOut = wrk[DW-1];
            end
            OP_SHR: begin
                shVal = {1'b0, wrk[DW-1:1]};
                shOut = wrk[0];
            end
            OP_ASR: begin
                shVal = {wrk[DW-1], wrk[DW-1:1]};
                shOut = wrk[0];
            end
            default: ;
        endcase
    end

    // Next-state, datapath step and completion select
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        opNxt    = opReg;
        sfNxt    = sfReg;
        wrkNxt   = wrk;
        mcandNxt = mcand;
        mplrNxt  = mplr;
        accNxt   = acc;
        fin      = 1'b0;
        finLegal = 1'b0;
        finRes   = '0;
        finC     = 1'b0;
        finV     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    opNxt = bus.op;
                    sfNxt = bus.setFlags;
                    case (bus.op)
                        OP_ADD: begin
                            fin      = 1'b1;
                            finLegal = 1'b1;
                            finRes   = addSum[DW-1:0];
                            finC     = addSum[DW];
                            finV     = (bus.opA[DW-1] == bus.opB[DW-1])
                                    && (addSum[DW-1] != bus.opA[DW-1]);
                        end
                        OP_SUB: begin
                            fin      = 1'b1;
                            finLegal = 1'b1;
                            finRes   = subSum[DW-1:0];
                            finC     = subSum[DW];
                            finV     = (bus.opA[DW-1] != bus.opB[DW-1])
                                    && (subSum[DW-1] != bus.opA[DW-1]);
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                            fin      = 1'b1;
                            finLegal = 1'b1;
                            case (bus.op)
                                OP_AND:  finRes = bus.opA & bus.opB;
                                OP_OR:   finRes = bus.opA | bus.opB;
                                OP_XOR:  finRes = bus.opA ^ bus.opB;
                                default: finRes = ~bus.opA;
                            endcase
                        end
                        OP_SHL, OP_SHR, OP_ASR: begin
                            if (amt == '0) begin
                                fin      = 1'b1;
                                finLegal = 1'b1;
                                finRes   = bus.opA;
                            end else begin
                                stateNxt = SHIFT;
                                cntNxt   = {1'b0, amt};
                                wrkNxt   = bus.opA;
                            end
                        end
                        OP_MUL: begin
                            stateNxt = MUL;
                            cntNxt   = CW'(DW);
                            mcandNxt = {{DW{1'b0}}, bus.opA};
                            mplrNxt  = bus.opB;
                            accNxt   = '0;
                        end
                        default: fin = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                wrkNxt = shVal;
                cntNxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    stateNxt = IDLE;
                    fin      = 1'b1;
                    finLegal = 1'b1;
                    finRes   = shVal;
                    finC     = shOut;
                end
            end
            MUL: begin
                accNxt   = mulStep;
                mcandNxt = {mcand[2*DW-2:0], 1'b0};
                mplrNxt  = {1'b0, mplr[DW-1:1]};
                cntNxt   = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    stateNxt = IDLE;
                    fin      = 1'b1;
                    finLegal = 1'b1;
                    finRes   = mulStep[DW-1:0];
                    finC     = |mulStep[2*DW-1:DW];
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    alu_flag_gen uFlag (
        .res   (finRes),
        .carry (finC),
        .ovf   (finV),
        .flags (finFlags)
    );

    // FSM, operand and output registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= IDLE;
            cnt     <= '0;
            opReg   <= '0;
            sfReg   <= 1'b0;
            wrk     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            doneR   <= 1'b0;
            flagWeR <= 1'b0;
            resultR <= '0;
            condR   <= 4'b0000;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            opReg   <= opNxt;
            sfReg   <= sfNxt;
            wrk     <= wrkNxt;
            mcand   <= mcandNxt;
            mplr    <= mplrNxt;
            acc     <= accNxt;
            doneR   <= fin;
            flagWeR <= fin && finLegal && sfNxt;
            if (fin)
                resultR <= finRes;
            if (fin && finLegal && sfNxt)
                condR <= finFlags;
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = doneR;
    assign bus.flagWe   = flagWeR;
    assign bus.result   = resultR;
    assign bus.condFlag = condR;

endmodule
